// File: rtl/button_debouncer_pkg.sv
// Shared constants and helpers for the push-button debouncer.
// Level encoding is after polarity normalisation: 1 means pressed.
package button_debouncer_pkg;

    localparam int DEBOUNCE_DEFAULT_CYCLES = 1000000;

    localparam logic BTN_PRESSED  = 1'b1;
    localparam logic BTN_RELEASED = 1'b0;

    typedef enum logic [1:0] {
        DB_IDLE,
        DB_COUNT,
        DB_ACCEPT
    } db_state_e;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// Button bundle between the raw pins and the debounced consumer (PIO in_port).
interface button_debouncer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] btn_raw;
    logic [WIDTH-1:0] btn_level;
    logic [WIDTH-1:0] press_pulse;
    logic [WIDTH-1:0] release_pulse;

    modport master (
        output btn_raw,
        input  btn_level,
        input  press_pulse,
        input  release_pulse
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output press_pulse,
        output release_pulse
    );
endinterface

// File: rtl/button_debouncer_channel.sv
// One debounce channel: two-flop synchroniser, qualification counter,
// stable level register and registered press/release strobes.
//
// state     | meaning
// ----------+---------------------------------------------------------
// DB_IDLE   | sync2 agrees with stable level, counter held at zero
// DB_COUNT  | sync2 differs, counting consecutive disagreeing cycles
// DB_ACCEPT | counter reached STABLE_CYCLES-1, adopt new level + strobe
module debounce_channel
    import button_debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = DEBOUNCE_DEFAULT_CYCLES,
    parameter bit INVERT        = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw_i,
    output logic btn_level_o,
    output logic press_pulse_o,
    output logic release_pulse_o
);

    localparam int CNT_W_RAW = clog2(STABLE_CYCLES);
    localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic             raw_norm;
    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    db_state_e        state;

    assign raw_norm = btn_raw_i ^ INVERT;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= BTN_RELEASED;
            sync2_q   <= BTN_RELEASED;
            stable_q  <= BTN_RELEASED;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= raw_norm;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    always_comb begin
        state     = DB_IDLE;
        stable_d  = stable_q;
        cnt_d     = '0;
        press_d   = 1'b0;
        release_d = 1'b0;

        if (sync2_q != stable_q) begin
            state = (cnt_q == CNT_MAX) ? DB_ACCEPT : DB_COUNT;
        end

        case (state)
            DB_IDLE: begin
                cnt_d = '0;
            end
            DB_COUNT: begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            DB_ACCEPT: begin
                stable_d  = sync2_q;
                cnt_d     = '0;
                press_d   = (sync2_q == BTN_PRESSED);
                release_d = (sync2_q == BTN_RELEASED);
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    assign btn_level_o     = stable_q;
    assign press_pulse_o   = press_q;
    assign release_pulse_o = release_q;

endmodule

// File: rtl/button_debouncer.sv
// WIDTH independent debounce channels feeding the button PIO in_port.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = DEBOUNCE_DEFAULT_CYCLES,
    parameter bit INVERT        = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    button_debouncer_if.slave btn
);

    logic [WIDTH-1:0] level_w;
    logic [WIDTH-1:0] press_w;
    logic [WIDTH-1:0] release_w;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .INVERT        (INVERT)
        ) u_ch (
            .clk             (clk),
            .reset_n         (reset_n),
            .btn_raw_i       (btn.btn_raw[i]),
            .btn_level_o     (level_w[i]),
            .press_pulse_o   (press_w[i]),
            .release_pulse_o (release_w[i])
        );
    end

    assign btn.btn_level     = level_w;
    assign btn.press_pulse   = press_w;
    assign btn.release_pulse = release_w;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with STABLE_CYCLES=8, INVERT=1, WIDTH=4.
module tb_button_debouncer;

    logic clk;
    logic reset_n;
    int   errors;
    int   checks;

    button_debouncer_if #(.WIDTH(4)) bus ();

    button_debouncer #(
        .WIDTH         (4),
        .STABLE_CYCLES (8),
        .INVERT        (1'b1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Leaves time 1 ns after the rising edge: outputs settled, inputs safe to drive.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [11:0] got;
        bus.btn_raw = 4'hF;
        reset_n     = 1'b0;
        repeat (3) tick();
        got = {bus.btn_level, bus.press_pulse, bus.release_pulse};
        checks++;
        if (got !== 12'h000) begin
            errors++;
            $display("FAIL reset_hold: got=%h want=%h", got, 12'h000);
        end
        reset_n = 1'b1;
        for (int t = 1; t <= 50; t++) begin
            tick();
            got = {bus.btn_level, bus.press_pulse, bus.release_pulse};
            checks++;
            if (got !== 12'h000) begin
                errors++;
                $display("FAIL reset_idle t=%0d: got=%h want=%h", t, got, 12'h000);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [11:0] got, exp;
        bus.btn_raw[0] = 1'b0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            exp = {(t >= 10) ? 4'h1 : 4'h0, (t == 10) ? 4'h1 : 4'h0, 4'h0};
            got = {bus.btn_level, bus.press_pulse, bus.release_pulse};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL clean_press t=%0d: got=%h want=%h", t, got, exp);
            end
        end
        bus.btn_raw[0] = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            exp = {(t >= 10) ? 4'h0 : 4'h1, 4'h0, (t == 10) ? 4'h1 : 4'h0};
            got = {bus.btn_level, bus.press_pulse, bus.release_pulse};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL clean_release t=%0d: got=%h want=%h", t, got, exp);
            end
        end
    endtask

    task automatic test_bounce();
        int          seg_len [4];
        logic        seg_val [4];
        logic [11:0] got;
        seg_len = '{7, 3, 7, 12};
        seg_val = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int s = 0; s < 4; s++) begin
            bus.btn_raw[1] = seg_val[s];
            for (int t = 1; t <= seg_len[s]; t++) begin
                tick();
                got = {bus.btn_level, bus.press_pulse, bus.release_pulse};
                checks++;
                if (got !== 12'h000) begin
                    errors++;
                    $display("FAIL bounce seg=%0d t=%0d: got=%h want=%h", s, t, got, 12'h000);
                end
            end
        end
    endtask

    task automatic test_boundary();
        logic [11:0] got, exp;
        bus.btn_raw[2] = 1'b0;
        for (int t = 1; t <= 22; t++) begin
            tick();
            if (t == 7) bus.btn_raw[2] = 1'b1;
            got = {bus.btn_level, bus.press_pulse, bus.release_pulse};
            checks++;
            if (got !== 12'h000) begin
                errors++;
                $display("FAIL boundary_7 t=%0d: got=%h want=%h", t, got, 12'h000);
            end
        end
        bus.btn_raw[2] = 1'b0;
        for (int t = 1; t <= 25; t++) begin
            tick();
            if (t == 8) bus.btn_raw[2] = 1'b1;
            exp = {(t >= 10 && t < 18) ? 4'h4 : 4'h0,
                   (t == 10) ? 4'h4 : 4'h0,
                   (t == 18) ? 4'h4 : 4'h0};
            got = {bus.btn_level, bus.press_pulse, bus.release_pulse};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL boundary_8 t=%0d: got=%h want=%h", t, got, exp);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [11:0] got, exp;
        bus.btn_raw = 4'h0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            exp = {(t >= 10) ? 4'hF : 4'h0, (t == 10) ? 4'hF : 4'h0, 4'h0};
            got = {bus.btn_level, bus.press_pulse, bus.release_pulse};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL simul_press t=%0d: got=%h want=%h", t, got, exp);
            end
        end
        bus.btn_raw = 4'hF;
        for (int t = 1; t <= 12; t++) begin
            tick();
            exp = {(t >= 10) ? 4'h0 : 4'hF, 4'h0, (t == 10) ? 4'hF : 4'h0};
            got = {bus.btn_level, bus.press_pulse, bus.release_pulse};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL simul_release t=%0d: got=%h want=%h", t, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] got, exp;
        // Channel 3 pressed and accepted so the reset has a visible level to clear.
        bus.btn_raw = 4'h7;
        for (int t = 1; t <= 12; t++) begin
            tick();
            exp = {(t >= 10) ? 4'h8 : 4'h0, (t == 10) ? 4'h8 : 4'h0, 4'h0};
            got = {bus.btn_level, bus.press_pulse, bus.release_pulse};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL mid_pre t=%0d: got=%h want=%h", t, got, exp);
            end
        end
        bus.btn_raw = 4'h6;
        for (int t = 1; t <= 7; t++) begin
            tick();
            got = {bus.btn_level, bus.press_pulse, bus.release_pulse};
            checks++;
            if (got !== 12'h800) begin
                errors++;
                $display("FAIL mid_count t=%0d: got=%h want=%h", t, got, 12'h800);
            end
        end
        reset_n = 1'b0;
        #1;
        got = {bus.btn_level, bus.press_pulse, bus.release_pulse};
        checks++;
        if (got !== 12'h000) begin
            errors++;
            $display("FAIL mid_async_clear: got=%h want=%h", got, 12'h000);
        end
        repeat (2) tick();
        reset_n = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            exp = {(t >= 10) ? 4'h9 : 4'h0, (t == 10) ? 4'h9 : 4'h0, 4'h0};
            got = {bus.btn_level, bus.press_pulse, bus.release_pulse};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL mid_requalify t=%0d: got=%h want=%h", t, got, exp);
            end
        end
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        reset_n     = 1'b0;
        bus.btn_raw = 4'hF;
        test_reset();
        test_clean_press();
        test_bounce();
        test_boundary();
        test_simultaneous();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Synchronises and debounces the raw push-button inputs of the board before they reach the button PIO's `in_port`. Each channel is sampled through a two-flop synchroniser and only changes its clean output level after the input has held a new value for a programmable number of consecutive clock cycles. The block also emits one-cycle press and release strobes per channel. The PIO performs edge capture and IRQ generation on the clean levels. Optional polarity inversion maps the active-low board keys to active-high "pressed" levels.

## Interface

Parameters:
- `WIDTH`, default 4: number of button channels.
- `STABLE_CYCLES`, default 1000000: consecutive stable cycles required to accept a new level (20 ms at 50 MHz). Legal range is 1 to 2^24.
- `INVERT`, default 1: when 1, a raw low input means pressed (output 1).

Ports:
- `clk`, input, 1: system clock.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `btn_raw`, input, WIDTH: asynchronous raw button pins.
- `btn_level`, output, WIDTH: debounced level, 1 = pressed. Drives the PIO `in_port`.
- `press_pulse`, output, WIDTH: one-cycle strobe when a channel's `btn_level` goes 0→1.
- `release_pulse`, output, WIDTH: one-cycle strobe when a channel's `btn_level` goes 1→0.

## Operation

- Per channel, the polarity-normalised input is `raw_n = btn_raw ^ INVERT`. It passes through `sync1` then `sync2`, two flops clocked by `clk`.
- Per channel state: `stable` (drives `btn_level`) and a counter `cnt` of width `clog2(STABLE_CYCLES)`, minimum 1 bit.
- Each rising edge applies exactly one of these rules:
  - If `sync2 == stable`: `cnt <= 0`, no change. This is the IDLE state.
  - If `sync2 != stable` and `cnt < STABLE_CYCLES-1`: `cnt <= cnt+1`. This is the COUNTING state.
  - If `sync2 != stable` and `cnt == STABLE_CYCLES-1`: `stable <= sync2`, `cnt <= 0`. The matching `press_pulse` or `release_pulse` is registered high for exactly this next cycle.
- A bounce shorter than `STABLE_CYCLES` returns to IDLE with the counter cleared. No output change and no pulse occur.
- Channels are fully independent. Simultaneous events on several channels produce pulses in the same cycle.
- `press_pulse` and `release_pulse` of one channel are never high together. The same channel cannot produce pulses on two consecutive cycles unless `STABLE_CYCLES == 1`.
- Reset values:
  - `sync1` and `sync2` reset to 0 (the normalised released value), so a released key after reset produces no event.
  - `stable`, `cnt`, `btn_level`, `press_pulse` and `release_pulse` all reset to 0.
- Reset asserted mid-count aborts the count immediately. After release of reset, a still-pressed key is re-qualified from zero and yields a full press event.

## Timing

- Latency: if the raw input changes and is first sampled by `sync1` at edge k, then `btn_level` and the pulse update at edge k+STABLE_CYCLES+1. With STABLE_CYCLES=8, the update is 9 edges after the sampling edge.
- All outputs are registered. There is no combinational path from `btn_raw` to any output.
- A level held for exactly STABLE_CYCLES-1 cycles at `sync2`, then reverting, must not be accepted.
- Counter wrap-around is impossible: the counter clears on acceptance or on agreement.
- Reset deassertion needs no synchroniser inside this block; it is handled system-wide.

## Structure

- The shared package/include holds:
  - the `clog2` constant function;
  - `DEBOUNCE_DEFAULT_CYCLES` (1000000);
  - `BTN_PRESSED` and `BTN_RELEASED` level constants.
- One sub-module, `debounce_channel`, implements a 1-bit synchroniser, counter and stable register with its pulses. It takes `STABLE_CYCLES` and `INVERT` parameters.
- The top level instantiates `debounce_channel` WIDTH times in a generate loop and concatenates the outputs.

## Test plan

Run the bench with STABLE_CYCLES=8, INVERT=1, WIDTH=4.

1. **Reset with released keys.** Hold `btn_raw=4'hF` through reset and for 50 cycles. Require `btn_level=0` and no pulses throughout.
2. **Clean press.** Drive `btn_raw[0]` low at edge k. Require `btn_level=4'h1` and `press_pulse=4'h1` for one cycle at edge k+9. `release_pulse` stays 0.
3. **Bounce rejection.** Toggle `btn_raw[1]` low for 7 cycles, high for 3, low for 7, then high. Require `btn_level[1]` to stay 0 and no pulses.
4. **Boundary.** Hold `btn_raw[2]` low for exactly 7 sync cycles and require no change. Hold it low for 8 and require acceptance.
5. **Simultaneous events.** Drive `btn_raw[3:0]` from 4'hF to 4'h0 on the same edge. Require `press_pulse=4'hF` in one cycle. Then drive it back to 4'hF and require `release_pulse=4'hF` in one cycle.
6. **Reset mid-operation.** Assert `reset_n` while channel 0 is at cnt=5 with the key held. Require all outputs 0 immediately. After reset releases with the key still held, require the press to be accepted 9 edges after the first post-reset sampling edge.
